// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register. It also holds load-use hazard
// detection, which inserts one bubble, and a write-back bypass, which covers a
// register-file write and read of the same register in the same cycle.
//
// Ports
//   clk, reset                  pipeline clock; asynchronous active-low reset
//   id_readata1/2, id_imm       ID operands (rs data, rt data, sign-ext imm)
//   id_rs/rt/rd                 ID register specifiers
//   id_ctrl                     {RegWrite, MemtoReg, MemRead, MemWrite,
//                                ALUSrc, RegDst, ALUOp[1:0], Branch}
//   id_valid                    ID holds a real instruction
//   flush                       squash the instruction entering EX
//   wb_regwrite/writereg/
//   writedata                   write-back port, used for the bypass
//   ex_*                        registered EX-stage copies
//   stall                       combinational; freeze PC and IF/ID
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] id_readata1,
   input  logic [DATA_W-1:0] id_readata2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [8:0]        id_ctrl,
   input  logic              id_valid,
   input  logic              flush,
   input  logic              wb_regwrite,
   input  logic [REG_AW-1:0] wb_writereg,
   input  logic [DATA_W-1:0] wb_writedata,
   output logic [DATA_W-1:0] ex_readata1,
   output logic [DATA_W-1:0] ex_readata2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic [8:0]        ex_ctrl,
   output logic              ex_valid,
   output logic              stall
);

   // Bit position of MemRead inside the control vector.
   localparam int CTRL_MEMREAD = 6;

   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2;
   logic              bubble;

   // Load-use hazard: the load in EX writes a register the ID instruction
   // reads. Register 0 is hard-wired, so a load targeting it never stalls.
   always_comb begin
      stall = ex_valid & ex_ctrl[CTRL_MEMREAD] & (ex_rt != '0) & id_valid &
              ((ex_rt == id_rs) | (ex_rt == id_rt));
   end

   // Write-back bypass: the register file returns the old value when it is
   // written and read in the same cycle, so take the WB data directly.
   always_comb begin
      op1 = id_readata1;
      op2 = id_readata2;
      if (wb_regwrite && (wb_writereg != '0) && (wb_writereg == id_rs))
         op1 = wb_writedata;
      if (wb_regwrite && (wb_writereg != '0) && (wb_writereg == id_rt))
         op2 = wb_writedata;
   end

   // A flush takes precedence over a stall, but both produce the same single
   // bubble, so one combined term is enough.
   assign bubble = flush | stall;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; the pipeline register is reset
   // asynchronously so a stall driven from ex_* drops immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_readata1 <= '0;
         ex_readata2 <= '0;
         ex_imm      <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
         ex_ctrl     <= '0;
         ex_valid    <= 1'b0;
      end else if (bubble) begin
         ex_readata1 <= '0;
         ex_readata2 <= '0;
         ex_imm      <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
         ex_ctrl     <= '0;
         ex_valid    <= 1'b0;
      end else begin
         ex_readata1 <= op1;
         ex_readata2 <= op2;
         ex_imm      <= id_imm;
         ex_rs       <= id_rs;
         ex_rt       <= id_rt;
         ex_rd       <= id_rd;
         ex_ctrl     <= id_valid ? id_ctrl : 9'h000;
         ex_valid    <= id_valid;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage. Inputs change 1 ns after each rising edge;
// outputs are sampled at that point or shortly after, away from the edge.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   // Control encodings {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc,
   // RegDst, ALUOp[1:0], Branch}.
   localparam logic [8:0] CTRL_LW  = 9'h1D0; // RegWrite|MemtoReg|MemRead|ALUSrc
   localparam logic [8:0] CTRL_ADD = 9'h10C; // RegWrite|RegDst|ALUOp=10
   localparam logic [8:0] CTRL_ALL = 9'h1FF;

   logic              clk;
   logic              reset;
   logic [DATA_W-1:0] id_readata1, id_readata2, id_imm;
   logic [REG_AW-1:0] id_rs, id_rt, id_rd;
   logic [8:0]        id_ctrl;
   logic              id_valid;
   logic              flush;
   logic              wb_regwrite;
   logic [REG_AW-1:0] wb_writereg;
   logic [DATA_W-1:0] wb_writedata;
   logic [DATA_W-1:0] ex_readata1, ex_readata2, ex_imm;
   logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
   logic [8:0]        ex_ctrl;
   logic              ex_valid;
   logic              stall;

   int checks   = 0;
   int failures = 0;

   id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_readata1  (id_readata1),
      .id_readata2  (id_readata2),
      .id_imm       (id_imm),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rd        (id_rd),
      .id_ctrl      (id_ctrl),
      .id_valid     (id_valid),
      .flush        (flush),
      .wb_regwrite  (wb_regwrite),
      .wb_writereg  (wb_writereg),
      .wb_writedata (wb_writedata),
      .ex_readata1  (ex_readata1),
      .ex_readata2  (ex_readata2),
      .ex_imm       (ex_imm),
      .ex_rs        (ex_rs),
      .ex_rt        (ex_rt),
      .ex_rd        (ex_rd),
      .ex_ctrl      (ex_ctrl),
      .ex_valid     (ex_valid),
      .stall        (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed,
                        input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic valid, input logic [8:0] ctrl,
                           input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                           input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] r1,
                           input logic [DATA_W-1:0] r2, input logic [DATA_W-1:0] imm);
      id_valid    = valid;
      id_ctrl     = ctrl;
      id_rs       = rs;
      id_rt       = rt;
      id_rd       = rd;
      id_readata1 = r1;
      id_readata2 = r2;
      id_imm      = imm;
   endtask

   initial begin
      reset        = 1'b0;
      flush        = 1'b0;
      wb_regwrite  = 1'b0;
      wb_writereg  = '0;
      wb_writedata = '0;
      drive_id(1'b0, 9'h000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      tick();
      tick();

      // Reset state.
      check("rst_valid", ex_valid, 1'b0);
      check("rst_ctrl",  ex_ctrl,  9'h000);
      check("rst_stall", stall,    1'b0);

      // First capture after reset release.
      reset = 1'b1;
      drive_id(1'b1, CTRL_ADD, 5'd1, 5'd2, 5'd3, 32'h34, 32'h77, 32'h0);
      tick();
      check("first_rd1",   ex_readata1, 32'h34);
      check("first_rd2",   ex_readata2, 32'h77);
      check("first_valid", ex_valid,    1'b1);
      check("first_ctrl",  ex_ctrl,     CTRL_ADD);
      check("first_rd",    ex_rd,       5'd3);

      // Load-use: lw $8 in EX, add reading $8 in ID.
      drive_id(1'b1, CTRL_LW, 5'd2, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h4);
      tick();
      check("lw_ctrl", ex_ctrl, CTRL_LW);
      check("lw_rt",   ex_rt,   5'd8);
      check("lw_imm",  ex_imm,  32'h4);
      drive_id(1'b1, CTRL_ADD, 5'd8, 5'd9, 5'd10, 32'h11, 32'h22, 32'h0);
      #1;
      check("lu_stall", stall, 1'b1);
      tick();
      check("lu_bubble_valid", ex_valid, 1'b0);
      check("lu_bubble_ctrl",  ex_ctrl,  9'h000);
      check("lu_stall_clear",  stall,    1'b0);
      tick();
      check("lu_add_valid", ex_valid,    1'b1);
      check("lu_add_ctrl",  ex_ctrl,     CTRL_ADD);
      check("lu_add_rs",    ex_rs,       5'd8);
      check("lu_add_rd1",   ex_readata1, 32'h11);

      // Asynchronous reset while a stall is asserted.
      drive_id(1'b1, CTRL_LW, 5'd2, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h4);
      tick();
      drive_id(1'b1, CTRL_ADD, 5'd8, 5'd9, 5'd10, 32'h11, 32'h22, 32'h0);
      #1;
      check("mid_stall_pre", stall, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_ctrl",  ex_ctrl,     9'h000);
      check("mid_rst_valid", ex_valid,    1'b0);
      check("mid_rst_rt",    ex_rt,       5'd0);
      check("mid_rst_imm",   ex_imm,      32'h0);
      check("mid_rst_stall", stall,       1'b0);
      tick();
      reset = 1'b1;

      // No false stall: load to $0.
      drive_id(1'b1, CTRL_LW, 5'd2, 5'd0, 5'd0, 32'h1000, 32'h0, 32'h8);
      tick();
      check("lw0_ctrl", ex_ctrl, CTRL_LW);
      drive_id(1'b1, CTRL_ADD, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0);
      #1;
      check("lw0_nostall", stall, 1'b0);

      // No false stall: unrelated specifiers.
      drive_id(1'b1, CTRL_LW, 5'd2, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h8);
      tick();
      drive_id(1'b1, CTRL_ADD, 5'd9, 5'd10, 5'd11, 32'h0, 32'h0, 32'h0);
      #1;
      check("unrel_nostall", stall, 1'b0);

      // WB bypass on both operands.
      wb_regwrite  = 1'b1;
      wb_writereg  = 5'd5;
      wb_writedata = 32'hDEAD;
      drive_id(1'b1, CTRL_ADD, 5'd5, 5'd5, 5'd6, 32'h536, 32'h536, 32'h0);
      tick();
      check("byp_rd1", ex_readata1, 32'hDEAD);
      check("byp_rd2", ex_readata2, 32'hDEAD);

      // Register 0 is never bypassed.
      wb_writereg = 5'd0;
      drive_id(1'b1, CTRL_ADD, 5'd0, 5'd5, 5'd6, 32'h536, 32'h536, 32'h0);
      tick();
      check("byp0_rd1", ex_readata1, 32'h536);
      check("byp0_rd2", ex_readata2, 32'h536);

      // No bypass when WB is not writing.
      wb_regwrite = 1'b0;
      wb_writereg = 5'd5;
      drive_id(1'b1, CTRL_ADD, 5'd5, 5'd5, 5'd6, 32'h536, 32'h777, 32'h0);
      tick();
      check("nobyp_rd1", ex_readata1, 32'h536);
      check("nobyp_rd2", ex_readata2, 32'h777);
      wb_writereg  = 5'd0;
      wb_writedata = 32'h0;

      // Flush together with a load-use stall: a single bubble.
      drive_id(1'b1, CTRL_LW, 5'd2, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h4);
      tick();
      drive_id(1'b1, CTRL_ADD, 5'd1, 5'd8, 5'd12, 32'h21, 32'h31, 32'h0);
      flush = 1'b1;
      #1;
      check("fl_stall", stall, 1'b1);
      tick();
      flush = 1'b0;
      check("fl_bubble_valid", ex_valid, 1'b0);
      check("fl_bubble_ctrl",  ex_ctrl,  9'h000);
      check("fl_stall_clear",  stall,    1'b0);
      tick();
      check("fl_next_valid", ex_valid,    1'b1);
      check("fl_next_ctrl",  ex_ctrl,     CTRL_ADD);
      check("fl_next_rd2",   ex_readata2, 32'h31);

      // Back-to-back loads to $8: each one stalls its consumer once.
      drive_id(1'b1, CTRL_LW, 5'd2, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h4);
      tick();
      drive_id(1'b1, CTRL_LW, 5'd8, 5'd8, 5'd0, 32'h0, 32'h0, 32'h8);
      #1;
      check("b2b_stall1", stall, 1'b1);
      tick();
      check("b2b_stall1_clear", stall, 1'b0);
      tick();
      check("b2b_lw2_ctrl", ex_ctrl, CTRL_LW);
      drive_id(1'b1, CTRL_ADD, 5'd8, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0);
      #1;
      check("b2b_stall2", stall, 1'b1);
      tick();
      check("b2b_bubble2", ex_valid, 1'b0);

      // Invalid ID: control dropped, specifiers still captured.
      drive_id(1'b1, CTRL_LW, 5'd2, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h4);
      tick();
      drive_id(1'b0, CTRL_ALL, 5'd8, 5'd8, 5'd8, 32'h0, 32'h0, 32'h0);
      #1;
      check("inv_nostall", stall, 1'b0);
      tick();
      check("inv_ctrl",  ex_ctrl,  9'h000);
      check("inv_valid", ex_valid, 1'b0);
      check("inv_rs",    ex_rs,    5'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
